// File: rtl/sdrc_bank_req_queue_if.sv
// rtl/sdrc_bank_req_queue_if.sv - request-generator to bank-control handshake bundle
interface sdrc_bank_req_queue_if #(
  parameter int DEPTH        = 4,
  parameter int REQ_BW       = 12,
  parameter int SDR_REQ_ID_W = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  // request side
  logic                    r2b_req;
  logic [SDR_REQ_ID_W-1:0] r2b_req_id;
  logic                    r2b_start;
  logic                    r2b_last;
  logic                    r2b_wrap;
  logic                    r2b_write;
  logic [1:0]              r2b_ba;
  logic [12:0]             r2b_raddr;
  logic [12:0]             r2b_caddr;
  logic [REQ_BW-1:0]       r2b_len;
  logic                    b2r_ack;
  logic                    b2r_arb_ok;

  // head-of-queue side
  logic                    q_valid;
  logic                    q_ready;
  logic [SDR_REQ_ID_W-1:0] q_req_id;
  logic                    q_start;
  logic                    q_last;
  logic                    q_wrap;
  logic                    q_write;
  logic [1:0]              q_ba;
  logic [12:0]             q_raddr;
  logic [12:0]             q_caddr;
  logic [REQ_BW-1:0]       q_len;
  logic                    q_row_hit;
  logic [CW-1:0]           q_count;

  // precharge notifications
  logic [3:0]              bank_close;
  logic                    close_all;

  modport master (
    output r2b_req, r2b_req_id, r2b_start, r2b_last, r2b_wrap, r2b_write,
           r2b_ba, r2b_raddr, r2b_caddr, r2b_len, q_ready, bank_close, close_all,
    input  b2r_ack, b2r_arb_ok, q_valid, q_req_id, q_start, q_last, q_wrap,
           q_write, q_ba, q_raddr, q_caddr, q_len, q_row_hit, q_count
  );

  modport slave (
    input  r2b_req, r2b_req_id, r2b_start, r2b_last, r2b_wrap, r2b_write,
           r2b_ba, r2b_raddr, r2b_caddr, r2b_len, q_ready, bank_close, close_all,
    output b2r_ack, b2r_arb_ok, q_valid, q_req_id, q_start, q_last, q_wrap,
           q_write, q_ba, q_raddr, q_caddr, q_len, q_row_hit, q_count
  );
endinterface

// File: rtl/sdrc_bank_req_queue.sv
// rtl/sdrc_bank_req_queue.sv - in-order bank request FIFO with open-row tracking
module sdrc_bank_req_queue #(
  parameter int DEPTH        = 4,
  parameter int REQ_BW       = 12,
  parameter int SDR_REQ_ID_W = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  sdrc_bank_req_queue_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]           r_wr_ptr;
  logic [AW-1:0]           r_rd_ptr;
  logic [CW-1:0]           r_count;

  logic [SDR_REQ_ID_W-1:0] r_id    [DEPTH];
  logic                    r_start [DEPTH];
  logic                    r_last  [DEPTH];
  logic                    r_wrap  [DEPTH];
  logic                    r_write [DEPTH];
  logic [1:0]              r_ba    [DEPTH];
  logic [12:0]             r_raddr [DEPTH];
  logic [12:0]             r_caddr [DEPTH];
  logic [REQ_BW-1:0]       r_len   [DEPTH];

  logic [3:0]              r_open_valid;
  logic [12:0]             r_open_row [4];

  logic                    w_push;
  logic                    w_pop;
  logic                    w_q_valid;

  // Ack is withheld during reset so the generator never sees a request accepted into a queue being cleared.
  assign w_q_valid      = (r_count != '0);
  assign w_push         = reset_n & bus.r2b_req & (r_count < CW'(DEPTH));
  assign w_pop          = w_q_valid & bus.q_ready;

  assign bus.b2r_ack    = w_push;
  // Two free slots leave room for both halves of a page-split request.
  assign bus.b2r_arb_ok = (CW'(DEPTH) - r_count) >= CW'(2);
  assign bus.q_valid    = w_q_valid;
  assign bus.q_count    = r_count;

  // Head fields are zeroed when the queue is empty so stale entries never leak out.
  assign bus.q_req_id   = w_q_valid ? r_id[r_rd_ptr]    : '0;
  assign bus.q_start    = w_q_valid ? r_start[r_rd_ptr] : 1'b0;
  assign bus.q_last     = w_q_valid ? r_last[r_rd_ptr]  : 1'b0;
  assign bus.q_wrap     = w_q_valid ? r_wrap[r_rd_ptr]  : 1'b0;
  assign bus.q_write    = w_q_valid ? r_write[r_rd_ptr] : 1'b0;
  assign bus.q_ba       = w_q_valid ? r_ba[r_rd_ptr]    : '0;
  assign bus.q_raddr    = w_q_valid ? r_raddr[r_rd_ptr] : '0;
  assign bus.q_caddr    = w_q_valid ? r_caddr[r_rd_ptr] : '0;
  assign bus.q_len      = w_q_valid ? r_len[r_rd_ptr]   : '0;

  assign bus.q_row_hit  = w_q_valid & r_open_valid[bus.q_ba] &
                          (r_open_row[bus.q_ba] == bus.q_raddr);

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage needs no reset: the head is masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_id[r_wr_ptr]    <= bus.r2b_req_id;
      r_start[r_wr_ptr] <= bus.r2b_start;
      r_last[r_wr_ptr]  <= bus.r2b_last;
      r_wrap[r_wr_ptr]  <= bus.r2b_wrap;
      r_write[r_wr_ptr] <= bus.r2b_write;
      r_ba[r_wr_ptr]    <= bus.r2b_ba;
      r_raddr[r_wr_ptr] <= bus.r2b_raddr;
      r_caddr[r_wr_ptr] <= bus.r2b_caddr;
      r_len[r_wr_ptr]   <= bus.r2b_len;
    end
  end

  // Open-row table: closes applied first, then a pop re-opens its bank so it wins a same-cycle close.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_open_valid <= '0;
      for (int b = 0; b < 4; b++) r_open_row[b] <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (bus.close_all || bus.bank_close[b]) r_open_valid[b] <= 1'b0;
      end
      if (w_pop) begin
        r_open_valid[bus.q_ba] <= 1'b1;
        r_open_row[bus.q_ba]   <= bus.q_raddr;
      end
    end
  end
endmodule

// File: tb/tb_sdrc_bank_req_queue.sv
// tb/tb_sdrc_bank_req_queue.sv - directed self-checking bench for sdrc_bank_req_queue
module tb_sdrc_bank_req_queue;
  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_err;

  sdrc_bank_req_queue_if #(.DEPTH(4), .REQ_BW(12), .SDR_REQ_ID_W(4)) bus ();

  sdrc_bank_req_queue #(.DEPTH(4), .REQ_BW(12), .SDR_REQ_ID_W(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Step to 1 ns after the next rising edge; inputs change here, checks follow 2 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [3:0] id, input logic [3:0] flg, input logic [1:0] ba,
                         input logic [12:0] ra, input logic [12:0] ca, input logic [11:0] len);
    bus.r2b_req    = 1'b1;
    bus.r2b_req_id = id;
    {bus.r2b_start, bus.r2b_last, bus.r2b_wrap, bus.r2b_write} = flg;
    bus.r2b_ba     = ba;
    bus.r2b_raddr  = ra;
    bus.r2b_caddr  = ca;
    bus.r2b_len    = len;
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    bus.r2b_req    = 1'b0;
    bus.q_ready    = 1'b0;
    bus.bank_close = 4'b0;
    bus.close_all  = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  // Push one entry over one clock (assumes room).
  task automatic push1(input logic [1:0] ba, input logic [12:0] ra);
    set_req(4'h3, 4'b1100, ba, ra, 13'h004, 12'h008);
    tick();
    bus.r2b_req = 1'b0;
  endtask

  task automatic pop1();
    bus.q_ready = 1'b1;
    tick();
    bus.q_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n        = 1'b0;
    bus.q_ready    = 1'b0;
    bus.bank_close = 4'b0;
    bus.close_all  = 1'b0;
    set_req(4'hA, 4'b1101, 2'd0, 13'h0AB, 13'h011, 12'h020);
    tick();
    tick();
    #2;
    n_cmp++; if (bus.b2r_ack !== 1'b0) begin n_err++; $display("FAIL rst_ack got %b exp 0", bus.b2r_ack); end
    reset_n = 1'b1;
    #1;
    n_cmp++; if (bus.b2r_arb_ok !== 1'b1) begin n_err++; $display("FAIL rst_arb_ok got %b exp 1", bus.b2r_arb_ok); end
    n_cmp++; if (bus.q_valid !== 1'b0) begin n_err++; $display("FAIL rst_q_valid got %b exp 0", bus.q_valid); end
    n_cmp++; if (bus.q_count !== 3'd0) begin n_err++; $display("FAIL rst_q_count got %0d exp 0", bus.q_count); end
    n_cmp++; if (bus.q_row_hit !== 1'b0) begin n_err++; $display("FAIL rst_row_hit got %b exp 0", bus.q_row_hit); end
    n_cmp++; if (bus.b2r_ack !== 1'b1) begin n_err++; $display("FAIL rst_first_ack got %b exp 1", bus.b2r_ack); end
    tick();
    bus.r2b_req = 1'b0;
    #2;
    n_cmp++; if (bus.q_valid !== 1'b1 || bus.q_count !== 3'd1) begin
      n_err++; $display("FAIL rst_first_push got valid=%b count=%0d exp valid=1 count=1", bus.q_valid, bus.q_count); end
    n_cmp++; if (bus.q_req_id !== 4'hA) begin n_err++; $display("FAIL rst_first_id got %h exp a", bus.q_req_id); end
  endtask

  task automatic test_fill_drain();
    logic [47:0] exp_f;
    logic [47:0] got_f;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_req(4'(i + 5), 4'(i * 3), 2'(i), 13'h100 + 13'(i), 13'h020 * 13'(i), 12'h010 + 12'(i));
      #2;
      n_cmp++; if (bus.b2r_ack !== 1'b1) begin n_err++; $display("FAIL fill_ack%0d got %b exp 1", i, bus.b2r_ack); end
      n_cmp++; if (bus.b2r_arb_ok !== (i <= 2)) begin
        n_err++; $display("FAIL fill_arb_ok%0d got %b exp %b", i, bus.b2r_arb_ok, (i <= 2)); end
      tick();
    end
    #2;
    n_cmp++; if (bus.q_count !== 3'd4) begin n_err++; $display("FAIL full_count got %0d exp 4", bus.q_count); end
    n_cmp++; if (bus.b2r_ack !== 1'b0) begin n_err++; $display("FAIL full_ack got %b exp 0", bus.b2r_ack); end
    n_cmp++; if (bus.b2r_arb_ok !== 1'b0) begin n_err++; $display("FAIL full_arb_ok got %b exp 0", bus.b2r_arb_ok); end
    bus.r2b_req = 1'b0;
    bus.q_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_f = {4'(i + 5), 4'(i * 3), 2'(i), 13'h100 + 13'(i), 13'h020 * 13'(i), 12'h010 + 12'(i)};
      got_f = {bus.q_req_id, bus.q_start, bus.q_last, bus.q_wrap, bus.q_write,
               bus.q_ba, bus.q_raddr, bus.q_caddr, bus.q_len};
      n_cmp++; if (bus.q_valid !== 1'b1 || got_f !== exp_f) begin
        n_err++; $display("FAIL drain%0d got valid=%b f=%h exp valid=1 f=%h", i, bus.q_valid, got_f, exp_f); end
      tick();
    end
    bus.q_ready = 1'b0;
    #2;
    n_cmp++; if (bus.q_valid !== 1'b0 || bus.q_count !== 3'd0 || bus.q_raddr !== 13'h0) begin
      n_err++; $display("FAIL empty_after_drain got valid=%b count=%0d raddr=%h exp 0/0/0",
                        bus.q_valid, bus.q_count, bus.q_raddr); end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < 4; i++) push1(2'(i), 13'h200 + 13'(i));
    set_req(4'hE, 4'b0011, 2'd3, 13'h1FFF, 13'h1FFF, 12'hFFF);
    bus.q_ready = 1'b1;
    #2;
    n_cmp++; if (bus.b2r_ack !== 1'b0) begin n_err++; $display("FAIL fullpp_ack got %b exp 0", bus.b2r_ack); end
    tick();
    bus.q_ready = 1'b0;
    #2;
    n_cmp++; if (bus.q_count !== 3'd3) begin n_err++; $display("FAIL fullpp_count got %0d exp 3", bus.q_count); end
    n_cmp++; if (bus.b2r_ack !== 1'b1) begin n_err++; $display("FAIL fullpp_ack2 got %b exp 1", bus.b2r_ack); end
    tick();
    bus.r2b_req = 1'b0;
    #2;
    n_cmp++; if (bus.q_count !== 3'd4 || bus.q_raddr !== 13'h201) begin
      n_err++; $display("FAIL fullpp_after got count=%0d raddr=%h exp 4/201", bus.q_count, bus.q_raddr); end
    bus.q_ready = 1'b1;
    tick(); tick(); tick();
    bus.q_ready = 1'b0;
    #2;
    n_cmp++; if (bus.q_req_id !== 4'hE || bus.q_raddr !== 13'h1FFF || bus.q_len !== 12'hFFF) begin
      n_err++; $display("FAIL wrap_entry got id=%h raddr=%h len=%h exp e/1fff/fff", bus.q_req_id, bus.q_raddr, bus.q_len); end
  endtask

  task automatic test_row_hit();
    do_reset();
    push1(2'd1, 13'h0123);
    #2;
    n_cmp++; if (bus.q_row_hit !== 1'b0) begin n_err++; $display("FAIL hit_cold got %b exp 0", bus.q_row_hit); end
    pop1();
    push1(2'd1, 13'h0123);
    #2;
    n_cmp++; if (bus.q_row_hit !== 1'b1) begin n_err++; $display("FAIL hit_same got %b exp 1", bus.q_row_hit); end
    pop1();
    push1(2'd1, 13'h0124);
    #2;
    n_cmp++; if (bus.q_row_hit !== 1'b0) begin n_err++; $display("FAIL hit_other_row got %b exp 0", bus.q_row_hit); end
    pop1();
    push1(2'd2, 13'h0124);
    #2;
    n_cmp++; if (bus.q_row_hit !== 1'b0) begin n_err++; $display("FAIL hit_other_bank got %b exp 0", bus.q_row_hit); end
  endtask

  task automatic test_bank_close();
    do_reset();
    push1(2'd2, 13'h0055);
    pop1();
    bus.bank_close = 4'b0100;
    tick();
    bus.bank_close = 4'b0000;
    push1(2'd2, 13'h0055);
    #2;
    n_cmp++; if (bus.q_row_hit !== 1'b0) begin n_err++; $display("FAIL close_bank2 got %b exp 0", bus.q_row_hit); end
    pop1();
    push1(2'd2, 13'h0055);
    #2;
    n_cmp++; if (bus.q_row_hit !== 1'b1) begin n_err++; $display("FAIL reopen_bank2 got %b exp 1", bus.q_row_hit); end
    bus.close_all = 1'b1;
    tick();
    bus.close_all = 1'b0;
    #2;
    n_cmp++; if (bus.q_row_hit !== 1'b0) begin n_err++; $display("FAIL close_all got %b exp 0", bus.q_row_hit); end
    bus.q_ready    = 1'b1;
    bus.bank_close = 4'b0100;
    tick();
    bus.q_ready    = 1'b0;
    bus.bank_close = 4'b0000;
    push1(2'd2, 13'h0055);
    #2;
    n_cmp++; if (bus.q_row_hit !== 1'b1) begin n_err++; $display("FAIL pop_wins_close got %b exp 1", bus.q_row_hit); end
  endtask

  task automatic test_page_split();
    do_reset();
    push1(2'd0, 13'h0300);
    push1(2'd1, 13'h0301);
    set_req(4'h7, 4'b1000, 2'd3, 13'h0400, 13'h03F0, 12'h010);
    #2;
    n_cmp++; if (bus.b2r_arb_ok !== 1'b1 || bus.b2r_ack !== 1'b1) begin
      n_err++; $display("FAIL split_first got arb_ok=%b ack=%b exp 1/1", bus.b2r_arb_ok, bus.b2r_ack); end
    tick();
    set_req(4'h7, 4'b0100, 2'd3, 13'h0401, 13'h0000, 12'h0F0);
    #2;
    n_cmp++; if (bus.b2r_ack !== 1'b1) begin n_err++; $display("FAIL split_second_ack got %b exp 1", bus.b2r_ack); end
    tick();
    bus.r2b_req = 1'b0;
    #2;
    n_cmp++; if (bus.q_count !== 3'd4 || bus.b2r_arb_ok !== 1'b0) begin
      n_err++; $display("FAIL split_full got count=%0d arb_ok=%b exp 4/0", bus.q_count, bus.b2r_arb_ok); end
    pop1();
    #2;
    n_cmp++; if (bus.q_count !== 3'd3) begin n_err++; $display("FAIL split_pop got %0d exp 3", bus.q_count); end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    #2;
    n_cmp++; if (bus.q_count !== 3'd0 || bus.q_valid !== 1'b0) begin
      n_err++; $display("FAIL midreset got count=%0d valid=%b exp 0/0", bus.q_count, bus.q_valid); end
    push1(2'd0, 13'h0300);
    #2;
    n_cmp++; if (bus.q_row_hit !== 1'b0) begin n_err++; $display("FAIL midreset_rows got %b exp 0", bus.q_row_hit); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_fill_drain();
    test_full_push_pop();
    test_row_hit();
    test_bank_close();
    test_page_split();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
